// File: rtl/usb_tx_pkg.sv
// Shared types and widths for the USB transmit scheduler slice.
package usb_tx_pkg;

    localparam int TOK_PKT_W  = 19;
    localparam int DATA_PKT_W = 72;
    localparam int PID_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        HS_SEND,
        WAIT_DONE,
        GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        SRC_HS,
        SRC_TOK,
        SRC_DATA
    } tx_src_t;

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Requester / encoder / DPDM-facing signals of the transmit scheduler.
// The master side belongs to the protocol handlers and the line driver,
// the slave side to the scheduler itself.
interface usb_tx_scheduler_if;
    import usb_tx_pkg::*;

    logic                  tok_req;
    logic [TOK_PKT_W-1:0]  tok_pkt;
    logic                  data_req;
    logic [DATA_PKT_W-1:0] data_pkt;
    logic                  hs_req;
    logic [PID_W-1:0]      hs_pid;
    logic                  out_done;

    logic                  tok_ack;
    logic                  data_ack;
    logic                  hs_ack;
    logic                  crc5_pkt_ready;
    logic [TOK_PKT_W-1:0]  crc5_pkt_in;
    logic                  crc16_pkt_ready;
    logic [DATA_PKT_W-1:0] crc16_pkt_in;
    logic                  ph_out_bit;
    logic                  ph_sending;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_timeout;

    modport master (
        output tok_req, tok_pkt, data_req, data_pkt, hs_req, hs_pid, out_done,
        input  tok_ack, data_ack, hs_ack,
        input  crc5_pkt_ready, crc5_pkt_in, crc16_pkt_ready, crc16_pkt_in,
        input  ph_out_bit, ph_sending, tx_busy, tx_done, tx_timeout
    );

    modport slave (
        input  tok_req, tok_pkt, data_req, data_pkt, hs_req, hs_pid, out_done,
        output tok_ack, data_ack, hs_ack,
        output crc5_pkt_ready, crc5_pkt_in, crc16_pkt_ready, crc16_pkt_in,
        output ph_out_bit, ph_sending, tx_busy, tx_done, tx_timeout
    );

endinterface

// File: rtl/usb_tx_priority_arb.sv
// Fixed-priority request picker: handshake beats token beats data.
// No fairness state; a losing requester simply keeps asking.
module usb_tx_priority_arb
    import usb_tx_pkg::*;
(
    input  logic    hs_req,
    input  logic    tok_req,
    input  logic    data_req,
    output logic    grant_valid,
    output tx_src_t grant_src
);

    // Pick the highest-priority active request
    always_comb begin
        grant_valid = hs_req | tok_req | data_req;
        grant_src   = SRC_HS;
        if (hs_req) begin
            grant_src = SRC_HS;
        end else if (tok_req) begin
            grant_src = SRC_TOK;
        end else if (data_req) begin
            grant_src = SRC_DATA;
        end
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Transmit scheduler: grants one packet at a time to the CRC5, CRC16 or
// raw handshake path, waits for the line driver to finish (or gives up),
// then enforces an inter-packet gap before the next grant.
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMR_W          = 8
) (
    input logic               clock,
    input logic               reset_n,
    usb_tx_scheduler_if.slave bus
);

    localparam logic [TMR_W-1:0] HS_LAST  = TMR_W'(PID_W - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    tx_state_t             state, state_nxt;
    logic [TMR_W-1:0]      tmr, tmr_nxt;
    logic [PID_W-1:0]      pid_sr, pid_sr_nxt;
    logic [TOK_PKT_W-1:0]  crc5_q, crc5_nxt;
    logic [DATA_PKT_W-1:0] crc16_q, crc16_nxt;
    logic                  crc5_rdy_q, crc5_rdy_nxt;
    logic                  crc16_rdy_q, crc16_rdy_nxt;
    logic                  tok_ack_q, tok_ack_nxt;
    logic                  data_ack_q, data_ack_nxt;
    logic                  hs_ack_q, hs_ack_nxt;
    logic                  done_q, done_nxt;
    logic                  timeout_q, timeout_nxt;
    logic                  launch_cycle;
    logic                  grant_valid;
    tx_src_t               grant_src;

    usb_tx_priority_arb u_arb (
        .hs_req      (bus.hs_req),
        .tok_req     (bus.tok_req),
        .data_req    (bus.data_req),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // The cycle carrying a pkt_ready strobe is the encoder's launch; the
    // timeout budget starts counting only after it.
    assign launch_cycle = crc5_rdy_q | crc16_rdy_q;

    // Next-state, counter and strobe decode
    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        pid_sr_nxt    = pid_sr;
        crc5_nxt      = crc5_q;
        crc16_nxt     = crc16_q;
        crc5_rdy_nxt  = 1'b0;
        crc16_rdy_nxt = 1'b0;
        tok_ack_nxt   = 1'b0;
        data_ack_nxt  = 1'b0;
        hs_ack_nxt    = 1'b0;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (grant_valid) begin
                    case (grant_src)
                        SRC_HS: begin
                            hs_ack_nxt = 1'b1;
                            pid_sr_nxt = bus.hs_pid;
                            state_nxt  = HS_SEND;
                        end
                        SRC_TOK: begin
                            tok_ack_nxt  = 1'b1;
                            crc5_nxt     = bus.tok_pkt;
                            crc5_rdy_nxt = 1'b1;
                            state_nxt    = WAIT_DONE;
                        end
                        SRC_DATA: begin
                            data_ack_nxt  = 1'b1;
                            crc16_nxt     = bus.data_pkt;
                            crc16_rdy_nxt = 1'b1;
                            state_nxt     = WAIT_DONE;
                        end
                        default: begin
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end

            HS_SEND: begin
                pid_sr_nxt = pid_sr >> 1;
                if (tmr == HS_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = WAIT_DONE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            WAIT_DONE: begin
                if (bus.out_done) begin
                    done_nxt  = 1'b1;
                    tmr_nxt   = '0;
                    state_nxt = GAP;
                end else if (tmr == TO_LAST) begin
                    timeout_nxt = 1'b1;
                    tmr_nxt     = '0;
                    state_nxt   = GAP;
                end else if (!launch_cycle) begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            default: begin
                tmr_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, PID shifter, latched packets and one-cycle strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmr         <= '0;
            pid_sr      <= '0;
            crc5_q      <= '0;
            crc16_q     <= '0;
            crc5_rdy_q  <= 1'b0;
            crc16_rdy_q <= 1'b0;
            tok_ack_q   <= 1'b0;
            data_ack_q  <= 1'b0;
            hs_ack_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tmr         <= tmr_nxt;
            pid_sr      <= pid_sr_nxt;
            crc5_q      <= crc5_nxt;
            crc16_q     <= crc16_nxt;
            crc5_rdy_q  <= crc5_rdy_nxt;
            crc16_rdy_q <= crc16_rdy_nxt;
            tok_ack_q   <= tok_ack_nxt;
            data_ack_q  <= data_ack_nxt;
            hs_ack_q    <= hs_ack_nxt;
            done_q      <= done_nxt;
            timeout_q   <= timeout_nxt;
        end
    end

    assign bus.tok_ack         = tok_ack_q;
    assign bus.data_ack        = data_ack_q;
    assign bus.hs_ack          = hs_ack_q;
    assign bus.crc5_pkt_ready  = crc5_rdy_q;
    assign bus.crc5_pkt_in     = crc5_q;
    assign bus.crc16_pkt_ready = crc16_rdy_q;
    assign bus.crc16_pkt_in    = crc16_q;
    assign bus.ph_sending      = (state == HS_SEND);
    assign bus.ph_out_bit      = (state == HS_SEND) & pid_sr[0];
    assign bus.tx_busy         = (state != IDLE);
    assign bus.tx_done         = done_q;
    assign bus.tx_timeout      = timeout_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler. A packet-level model predicts
// each grant from the pending requests and derives every strobe's cycle
// from the packet's timing rules relative to the grant cycle.
module tb_usb_tx_scheduler;
    import usb_tx_pkg::*;

    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 255;
    localparam int TMR_W          = 8;

    logic clock;
    logic reset_n;

    usb_tx_scheduler_if bus ();

    usb_tx_scheduler #(
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic                  pend_hs, pend_tok, pend_data;
    logic [PID_W-1:0]      cur_pid;
    logic [TOK_PKT_W-1:0]  cur_tok;
    logic [DATA_PKT_W-1:0] cur_data;
    logic [TOK_PKT_W-1:0]  exp_crc5;
    logic [DATA_PKT_W-1:0] exp_crc16;

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop if the sequence somehow stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [71:0] rand72();
        return {8'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input int t, input logic obs, input logic exp);
        check_output($sformatf("%s t=%0d", tag, t), 72'(obs), 72'(exp));
    endtask

    // Raise the chosen requests (already-pending ones keep their payload)
    task automatic apply_stimulus(input logic hs, input logic tok, input logic data,
                                  input logic [PID_W-1:0] pid,
                                  input logic [TOK_PKT_W-1:0] tp,
                                  input logic [DATA_PKT_W-1:0] dp);
        if (hs) begin
            pend_hs = 1'b1; cur_pid = pid; bus.hs_pid = pid; bus.hs_req = 1'b1;
        end
        if (tok) begin
            pend_tok = 1'b1; cur_tok = tp; bus.tok_pkt = tp; bus.tok_req = 1'b1;
        end
        if (data) begin
            pend_data = 1'b1; cur_data = dp; bus.data_pkt = dp; bus.data_req = 1'b1;
        end
    endtask

    // Everything idle and packet registers at their expected contents
    task automatic check_quiet(input string tag);
        check_bit({tag, " tok_ack"}, 0, bus.tok_ack, 1'b0);
        check_bit({tag, " data_ack"}, 0, bus.data_ack, 1'b0);
        check_bit({tag, " hs_ack"}, 0, bus.hs_ack, 1'b0);
        check_bit({tag, " crc5_rdy"}, 0, bus.crc5_pkt_ready, 1'b0);
        check_bit({tag, " crc16_rdy"}, 0, bus.crc16_pkt_ready, 1'b0);
        check_bit({tag, " ph_sending"}, 0, bus.ph_sending, 1'b0);
        check_bit({tag, " ph_out_bit"}, 0, bus.ph_out_bit, 1'b0);
        check_bit({tag, " tx_busy"}, 0, bus.tx_busy, 1'b0);
        check_bit({tag, " tx_done"}, 0, bus.tx_done, 1'b0);
        check_bit({tag, " tx_timeout"}, 0, bus.tx_timeout, 1'b0);
        check_output({tag, " crc5_pkt_in"}, 72'(bus.crc5_pkt_in), 72'(exp_crc5));
        check_output({tag, " crc16_pkt_in"}, bus.crc16_pkt_in, exp_crc16);
    endtask

    // Serve one packet: called at the falling edge of an IDLE cycle with at
    // least one request pending. od_off < 0 means the line never reports
    // done; otherwise out_done is raised od_off cycles into the wait phase
    // (capped at the expiry cycle). Returns at the falling edge of the next
    // IDLE cycle.
    task automatic serve_one(input int od_off);
        tx_src_t          kind;
        int               w0, xc, od, endc;
        logic             timed_out;
        logic [PID_W-1:0] g_pid;
        logic             exp_bit;

        kind  = pend_hs ? SRC_HS : (pend_tok ? SRC_TOK : SRC_DATA);
        g_pid = cur_pid;
        // handshake spends PID_W cycles serialising before waiting
        w0 = (kind == SRC_HS) ? PID_W : 0;
        // last cycle on which the wait may still succeed
        xc = w0 + ((kind == SRC_HS) ? 0 : 1) + TIMEOUT_CYCLES - 1;
        timed_out = (od_off < 0);
        od = timed_out ? -1 : w0 + od_off;
        if (od > xc) od = xc;
        endc = timed_out ? xc + 1 : od + 1;

        for (int t = 0; t <= endc + GAP_CYCLES; t++) begin
            @(negedge clock);
            if (t == 0) begin
                if (kind == SRC_TOK)  exp_crc5  = cur_tok;
                if (kind == SRC_DATA) exp_crc16 = cur_data;
            end
            check_bit("hs_ack", t, bus.hs_ack, kind == SRC_HS && t == 0);
            check_bit("tok_ack", t, bus.tok_ack, kind == SRC_TOK && t == 0);
            check_bit("data_ack", t, bus.data_ack, kind == SRC_DATA && t == 0);
            check_bit("crc5_rdy", t, bus.crc5_pkt_ready, kind == SRC_TOK && t == 0);
            check_bit("crc16_rdy", t, bus.crc16_pkt_ready, kind == SRC_DATA && t == 0);
            check_output($sformatf("crc5_pkt_in t=%0d", t), 72'(bus.crc5_pkt_in), 72'(exp_crc5));
            check_output($sformatf("crc16_pkt_in t=%0d", t), bus.crc16_pkt_in, exp_crc16);
            exp_bit = 1'b0;
            if (kind == SRC_HS && t < PID_W) exp_bit = g_pid[t];
            check_bit("ph_sending", t, bus.ph_sending, kind == SRC_HS && t < PID_W);
            check_bit("ph_out_bit", t, bus.ph_out_bit, exp_bit);
            check_bit("tx_done", t, bus.tx_done, !timed_out && t == endc);
            check_bit("tx_timeout", t, bus.tx_timeout, timed_out && t == endc);
            check_bit("tx_busy", t, bus.tx_busy, t < endc + GAP_CYCLES);

            if (t == 0) begin
                // requester lets go and scribbles on its bus
                case (kind)
                    SRC_HS:   begin bus.hs_req = 1'b0; pend_hs = 1'b0; bus.hs_pid = 8'($urandom()); end
                    SRC_TOK:  begin bus.tok_req = 1'b0; pend_tok = 1'b0; bus.tok_pkt = 19'($urandom()); end
                    default:  begin bus.data_req = 1'b0; pend_data = 1'b0; bus.data_pkt = rand72(); end
                endcase
            end
            // stray out_done while serialising or in the gap must be ignored
            bus.out_done = (t == od)
                        || (t < w0 && $urandom_range(0, 1) == 1)
                        || (t >= endc && t < endc + GAP_CYCLES && $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic serve_all_random();
        int off;
        while (pend_hs || pend_tok || pend_data) begin
            off = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 50));
            serve_one(off);
        end
    endtask

    initial begin
        logic [PID_W-1:0] rpid;
        int               mask;

        reset_n       = 1'b0;
        bus.tok_req   = 1'b0;
        bus.tok_pkt   = '0;
        bus.data_req  = 1'b0;
        bus.data_pkt  = '0;
        bus.hs_req    = 1'b0;
        bus.hs_pid    = '0;
        bus.out_done  = 1'b0;
        pend_hs       = 1'b0;
        pend_tok      = 1'b0;
        pend_data     = 1'b0;
        cur_pid       = '0;
        cur_tok       = '0;
        cur_data      = '0;
        exp_crc5      = '0;
        exp_crc16     = '0;

        // reset state
        @(negedge clock);
        @(negedge clock);
        check_quiet("reset");
        reset_n = 1'b1;

        // stray out_done in IDLE
        bus.out_done = 1'b1;
        @(negedge clock);
        check_quiet("idle stray done");
        bus.out_done = 1'b0;

        $display("[TB] token packet");
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 19'h2_A5C1, 72'h0);
        serve_one(40);

        $display("[TB] data packet");
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 19'h0, 72'hfef811b7682df6d8_C3);
        serve_one(int'($urandom_range(5, 60)));

        $display("[TB] handshake packet");
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hD2, 19'h0, 72'h0);
        serve_one(int'($urandom_range(0, 30)));

        $display("[TB] simultaneous requests");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'($urandom()), 19'($urandom()), rand72());
        serve_one(int'($urandom_range(0, 20)));
        serve_one(int'($urandom_range(0, 20)));
        serve_one(int'($urandom_range(0, 20)));

        $display("[TB] timeout and coincident done");
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 19'($urandom()), 72'h0);
        serve_one(-1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 19'h0, rand72());
        serve_one(100000);

        $display("[TB] random request mixes");
        for (int i = 0; i < 8; i++) begin
            mask = int'($urandom_range(1, 7));
            apply_stimulus(mask[0], mask[1], mask[2], 8'($urandom()), 19'($urandom()), rand72());
            serve_all_random();
        end

        $display("[TB] reset during handshake");
        rpid = 8'($urandom());
        apply_stimulus(1'b1, 1'b0, 1'b0, rpid, 19'h0, 72'h0);
        for (int t = 0; t <= 3; t++) begin
            @(negedge clock);
            check_bit("pre-reset hs_ack", t, bus.hs_ack, t == 0);
            check_bit("pre-reset ph_sending", t, bus.ph_sending, 1'b1);
            check_bit("pre-reset ph_out_bit", t, bus.ph_out_bit, rpid[t]);
        end
        reset_n   = 1'b0;
        exp_crc5  = '0;
        exp_crc16 = '0;
        #1;
        check_quiet("async reset");
        @(negedge clock);
        check_quiet("in reset");
        reset_n = 1'b1;
        serve_one(int'($urandom_range(0, 20)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Transmit-side scheduler for the USB encode chain (CRC5/CRC16 encoders → bit stuffer → NRZI → DP/DM driver).
- Accepts packet requests from three protocol-handler requesters: token (19-bit, CRC5 path), data (72-bit, CRC16 path) and handshake (8-bit PID, raw ph path).
- Grants one packet at a time, launches it into the correct encoder, and holds off further launches until DPDM reports out_done or a timeout fires.
- Enforces an inter-packet gap and reports completion or error.

Parameters:
- GAP_CYCLES, 2, idle cycles inserted after each packet before the next grant (≥1).
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_DONE before the packet is abandoned (≥16).
- TMR_W, 8, width of the shared gap/timeout counter; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tok_req  in  1  token packet request; held until tok_ack
- tok_pkt  in  19  token packet; valid while tok_req
- data_req  in  1  data packet request; held until data_ack
- data_pkt  in  72  data packet; valid while data_req
- hs_req  in  1  handshake request; held until hs_ack
- hs_pid  in  8  handshake PID byte; valid while hs_req
- out_done  in  1  DPDM end-of-packet pulse
- tok_ack, data_ack, hs_ack  out  1 each  one-cycle grant pulses
- crc5_pkt_ready  out  1  launch pulse to CRC5 encoder
- crc5_pkt_in  out  19  latched token packet
- crc16_pkt_ready  out  1  launch pulse to CRC16 encoder
- crc16_pkt_in  out  72  latched data packet
- ph_out_bit  out  1  serialized handshake bit to DPDM
- ph_sending  out  1  handshake bit valid to DPDM
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse on successful completion
- tx_timeout  out  1  one-cycle pulse when a packet is abandoned

Behaviour:
- Reset state: FSM in IDLE; counter 0; all outputs 0, including the latched packet registers.
- States: IDLE, HS_SEND, WAIT_DONE, GAP.
- Arbitration in IDLE uses fixed priority hs > tok > data, with no round-robin. A losing request stays pending.
- Grant at posedge k, when the sampled request is high:
  - The corresponding ack is high during cycle k only.
  - Token grant: crc5_pkt_in ← tok_pkt; crc5_pkt_ready is high for cycle k only. Next state is WAIT_DONE.
  - Data grant: crc16_pkt_in ← data_pkt; crc16_pkt_ready is high for cycle k only. Next state is WAIT_DONE.
  - Handshake grant: hs_pid is latched into a shift register. Next state is HS_SEND.
- Latched packet registers hold their value until the next grant of the same type. They are never cleared outside reset.
- Only one pkt_ready pulse ever occurs per grant. The two pkt_ready outputs are never high together.
- HS_SEND lasts exactly 8 cycles:
  - ph_sending = 1 throughout.
  - ph_out_bit = pid bit i on cycle i, LSB first.
  - Then go to WAIT_DONE with ph_sending = 0.
- WAIT_DONE:
  - The counter increments each cycle starting from 0.
  - If out_done = 1: tx_done pulses on the next cycle, then go to GAP.
  - Else if counter == TIMEOUT_CYCLES-1: tx_timeout pulses on the next cycle, then go to GAP.
  - If out_done and expiry coincide, out_done wins: tx_done pulses and tx_timeout does not.
- GAP: the counter is reloaded to 0 on entry. Stay for exactly GAP_CYCLES cycles, then go to IDLE.
- Requests and out_done arriving outside their accepting state are ignored; requests stay pending.
- A stray out_done in IDLE or GAP has no effect.
- Back-to-back throughput: one packet per (launch + transmit + GAP_CYCLES + 1 IDLE sample).
- Asynchronous reset mid-packet:
  - Immediately drops all strobes, ph_sending and tx_busy.
  - Returns to IDLE.
  - No tx_done or tx_timeout is emitted for the aborted packet.

Decomposition:
- Package usb_tx_pkg holds:
  - state enum tx_state_t {IDLE, HS_SEND, WAIT_DONE, GAP};
  - width constants TOK_PKT_W=19, DATA_PKT_W=72, PID_W=8;
  - a source enum {SRC_HS, SRC_TOK, SRC_DATA}.
- One sub-module is natural: usb_tx_priority_arb, a combinational fixed-priority grant from the three requests.
- The FSM, counter and PID shifter stay in usb_tx_scheduler.

Test Plan:
- Token only: tok_req=1, tok_pkt=19'h2_A5C1 → tok_ack and crc5_pkt_ready pulse on the same single cycle; crc5_pkt_in=19'h2_A5C1; out_done after 40 cycles → tx_done 1 cycle later; tx_busy low exactly 2 cycles after that.
- Data: data_pkt=72'hfef811b7682df6d8_C3 → crc16_pkt_ready single pulse, crc16_pkt_in matches; crc5_pkt_ready stays 0; tx_done follows out_done.
- Handshake: hs_pid=8'hD2 → ph_sending high 8 cycles; ph_out_bit sequence 0,1,0,0,1,0,1,1; then WAIT_DONE.
- Simultaneous hs_req, tok_req and data_req → hs_ack first, then tok_ack, then data_ack, each granted only after tx_done plus GAP; never two acks in one cycle.
- No out_done: tx_timeout pulses exactly TIMEOUT_CYCLES+1 cycles after the launch cycle; tx_done stays 0. Also drive out_done on the expiry cycle → tx_done only.
- Reset asserted mid-HS_SEND (cycle 3) → ph_sending=0 and tx_busy=0 immediately; after release, a still-held hs_req is re-granted and its PID is re-sent from bit 0.
